// File: rtl/wiener_block_stats_mc.sv
// Block statistics engine: per-channel mean/variance over 2^LOG2_SAMPLES samples,
// with ping-pong replay of each block's samples aligned to its statistics.
module wiener_block_stats_mc #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned LOG2_SAMPLES = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_of_frame,
  input  logic                                 data_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_in,
  input  logic [31:0]                          blocks_per_frame,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mean_out,
  output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] variance_out,
  output logic                                 stats_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_out,
  output logic                                 data_out_valid,
  output logic                                 frame_done
);

  localparam int unsigned N     = 1 << LOG2_SAMPLES;
  localparam int unsigned SUM_W = DATA_WIDTH + LOG2_SAMPLES;
  localparam int unsigned SQ_W  = 2 * DATA_WIDTH + LOG2_SAMPLES;
  localparam int unsigned SQM_W = 2 * DATA_WIDTH;
  localparam int unsigned IDX_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
  localparam int unsigned PIX_W = NUM_CHANNELS * DATA_WIDTH;

  typedef enum logic {InIdle, InAccum} in_state_e;
  typedef enum logic {RdIdle, RdBusy} rd_state_e;

  in_state_e in_state_q, in_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] pix;
  logic [NUM_CHANNELS-1:0][SUM_W-1:0]      acc_sum_q, acc_sum_d, sum_new, s2_sum_q, s2_sum_d;
  logic [NUM_CHANNELS-1:0][SQ_W-1:0]       acc_sq_q, acc_sq_d, sq_new, s2_sq_q, s2_sq_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] s3_mean_q;
  logic [NUM_CHANNELS-1:0][SQM_W-1:0]      s3_sqm_q, var_calc;

  logic [IDX_W-1:0] idx_q, idx_d, wr_idx, rd_idx_q, rd_idx_d, rd_sel_idx;
  logic [31:0]      blk_cnt_q, blk_cnt_d, cnt_base;
  logic             wr_bank_q, wr_bank_d, restart, wr_en;
  logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, s2_bank_q, s2_bank_d;
  logic             s3_valid_q, s3_last_q, s3_bank_q;
  logic             rd_bank_q, rd_bank_d, rd_sel_bank, rd_en;

  logic [PIX_W-1:0] mem_q [2][N];

  assign pix      = data_in;
  // A start_of_frame sample always restarts at index 0, even mid-block.
  assign restart  = start_of_frame && data_valid;
  assign wr_en    = data_valid && (restart || (in_state_q == InAccum));
  assign wr_idx   = restart ? '0 : idx_q;
  assign cnt_base = restart ? 32'd0 : blk_cnt_q;

  always_comb begin
    sum_new = '0;
    sq_new  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sum_new[c] = (restart ? '0 : acc_sum_q[c]) + SUM_W'(pix[c]);
      sq_new[c]  = (restart ? '0 : acc_sq_q[c]) + SQ_W'(pix[c]) * SQ_W'(pix[c]);
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    idx_d      = idx_q;
    blk_cnt_d  = blk_cnt_q;
    wr_bank_d  = wr_bank_q;
    acc_sum_d  = acc_sum_q;
    acc_sq_d   = acc_sq_q;
    s2_valid_d = 1'b0;
    s2_last_d  = 1'b0;
    s2_bank_d  = s2_bank_q;
    s2_sum_d   = s2_sum_q;
    s2_sq_d    = s2_sq_q;
    if (wr_en) begin
      in_state_d = InAccum;
      if (wr_idx == IDX_W'(N - 1)) begin
        s2_valid_d = 1'b1;
        s2_bank_d  = wr_bank_q;
        s2_sum_d   = sum_new;
        s2_sq_d    = sq_new;
        acc_sum_d  = '0;
        acc_sq_d   = '0;
        idx_d      = '0;
        wr_bank_d  = ~wr_bank_q;
        blk_cnt_d  = cnt_base + 32'd1;
        s2_last_d  = (blocks_per_frame != 32'd0) && (cnt_base + 32'd1 == blocks_per_frame);
        if (s2_last_d) in_state_d = InIdle;
      end else begin
        acc_sum_d = sum_new;
        acc_sq_d  = sq_new;
        idx_d     = wr_idx + IDX_W'(1);
        blk_cnt_d = cnt_base;
      end
    end
  end

  always_comb begin
    var_calc = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      var_calc[c] = s3_sqm_q[c] - SQM_W'(s3_mean_q[c]) * SQM_W'(s3_mean_q[c]);
    end
  end

  // Readout starts the same edge the statistics are published.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_idx_d    = rd_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_en       = 1'b0;
    rd_sel_bank = rd_bank_q;
    rd_sel_idx  = rd_idx_q;
    if (s3_valid_q) begin
      rd_en       = 1'b1;
      rd_sel_bank = s3_bank_q;
      rd_sel_idx  = '0;
      rd_bank_d   = s3_bank_q;
      rd_idx_d    = IDX_W'(1);
      rd_state_d  = (N > 1) ? RdBusy : RdIdle;
    end else if (rd_state_q == RdBusy) begin
      rd_en    = 1'b1;
      rd_idx_d = rd_idx_q + IDX_W'(1);
      if (rd_idx_q == IDX_W'(N - 1)) rd_state_d = RdIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank_q][wr_idx] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q     <= InIdle;
      rd_state_q     <= RdIdle;
      idx_q          <= '0;
      blk_cnt_q      <= '0;
      wr_bank_q      <= 1'b0;
      acc_sum_q      <= '0;
      acc_sq_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_last_q      <= 1'b0;
      s2_bank_q      <= 1'b0;
      s2_sum_q       <= '0;
      s2_sq_q        <= '0;
      s3_valid_q     <= 1'b0;
      s3_last_q      <= 1'b0;
      s3_bank_q      <= 1'b0;
      s3_mean_q      <= '0;
      s3_sqm_q       <= '0;
      rd_idx_q       <= '0;
      rd_bank_q      <= 1'b0;
      mean_out       <= '0;
      variance_out   <= '0;
      stats_valid    <= 1'b0;
      frame_done     <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      rd_state_q <= rd_state_d;
      idx_q      <= idx_d;
      blk_cnt_q  <= blk_cnt_d;
      wr_bank_q  <= wr_bank_d;
      acc_sum_q  <= acc_sum_d;
      acc_sq_q   <= acc_sq_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_bank_q  <= s2_bank_d;
      s2_sum_q   <= s2_sum_d;
      s2_sq_q    <= s2_sq_d;
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      s3_bank_q  <= s2_bank_q;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        s3_mean_q[c] <= DATA_WIDTH'(s2_sum_q[c] >> LOG2_SAMPLES);
        s3_sqm_q[c]  <= SQM_W'(s2_sq_q[c] >> LOG2_SAMPLES);
      end
      rd_idx_q       <= rd_idx_d;
      rd_bank_q      <= rd_bank_d;
      stats_valid    <= s3_valid_q;
      frame_done     <= s3_valid_q && s3_last_q;
      data_out_valid <= rd_en;
      if (s3_valid_q) begin
        mean_out     <= s3_mean_q;
        variance_out <= var_calc;
      end
      if (rd_en) data_out <= mem_q[rd_sel_bank][rd_sel_idx];
    end
  end

endmodule

// File: tb/tb_wiener_block_stats_mc.sv
// Scoreboard bench for wiener_block_stats_mc with two 8-bit channels, 8-sample blocks.
module tb_wiener_block_stats_mc;

  localparam int DW = 8;
  localparam int C  = 2;
  localparam int L  = 3;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_of_frame = 1'b0;
  logic            data_valid = 1'b0;
  logic [C*DW-1:0] data_in = '0;
  logic [31:0]     bpf = 32'd0;
  logic [C*DW-1:0]   mean_out;
  logic [C*2*DW-1:0] variance_out;
  logic              stats_valid;
  logic [C*DW-1:0]   data_out;
  logic              data_out_valid;
  logic              frame_done;

  wiener_block_stats_mc #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(C),
    .LOG2_SAMPLES(L)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_of_frame  (start_of_frame),
    .data_valid      (data_valid),
    .data_in         (data_in),
    .blocks_per_frame(bpf),
    .mean_out        (mean_out),
    .variance_out    (variance_out),
    .stats_valid     (stats_valid),
    .data_out        (data_out),
    .data_out_valid  (data_out_valid),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, n_stats = 0, n_fd = 0, n_dov = 0;

  typedef struct packed {
    logic [15:0] mean;
    logic [31:0] vr;
    logic        last;
    int          cyc;
  } stats_t;
  typedef struct packed {
    logic [15:0] pix;
    int          cyc;
  } data_t;

  stats_t exp_stats_q[$];
  data_t  exp_data_q[$];
  stats_t mon_se;
  data_t  mon_de;

  logic        m_active = 1'b0;
  int          m_idx = 0, m_cnt = 0;
  logic [15:0] m_blk[N];

  // Drive one cycle of input and advance the reference model.
  task automatic drive(input logic sof, input logic v, input logic [15:0] pix);
    stats_t e;
    data_t  d;
    int     sum, sq, mn, s;
    start_of_frame = sof;
    data_valid     = v;
    data_in        = pix;
    if (v && (sof || m_active)) begin
      if (sof) begin
        m_idx = 0;
        m_cnt = 0;
      end
      m_active     = 1'b1;
      m_blk[m_idx] = pix;
      m_idx++;
      if (m_idx == N) begin
        e = '0;
        for (int c = 0; c < C; c++) begin
          sum = 0;
          sq  = 0;
          for (int i = 0; i < N; i++) begin
            s   = int'(m_blk[i][c*DW +: DW]);
            sum += s;
            sq  += s * s;
          end
          mn = sum / N;
          e.mean[c*DW +: DW]     = 8'(mn);
          e.vr[c*2*DW +: 2*DW]   = 16'((sq / N) - mn * mn);
        end
        m_idx = 0;
        m_cnt++;
        e.last = (bpf != 0) && (m_cnt == int'(bpf));
        if (e.last) m_active = 1'b0;
        e.cyc = cyc + 3;
        exp_stats_q.push_back(e);
        for (int i = 0; i < N; i++) begin
          d.pix = m_blk[i];
          d.cyc = cyc + 3 + i;
          exp_data_q.push_back(d);
        end
      end
    end
    @(posedge clk);
    #1;
    start_of_frame = 1'b0;
    data_valid     = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (exp_stats_q.size() == 0 && exp_data_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_stats_q.size() > 0 && exp_stats_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stats_missing: got no stats_valid, required at cycle %0d (now %0d)",
                 exp_stats_q[0].cyc, cyc);
        void'(exp_stats_q.pop_front());
      end
      if (exp_data_q.size() > 0 && exp_data_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL data_missing: got no data_out_valid, required %h at cycle %0d (now %0d)",
                 exp_data_q[0].pix, exp_data_q[0].cyc, cyc);
        void'(exp_data_q.pop_front());
      end
      if (stats_valid) begin
        n_stats++;
        if (frame_done) n_fd++;
        checks++;
        if (exp_stats_q.size() == 0) begin
          errors++;
          $display("FAIL stats_unexpected: got stats_valid at cycle %0d, required none", cyc);
        end else begin
          mon_se = exp_stats_q.pop_front();
          if (mean_out !== mon_se.mean || variance_out !== mon_se.vr ||
              frame_done !== mon_se.last || cyc != mon_se.cyc) begin
            errors++;
            $display("FAIL stats: got mean=%h var=%h fd=%b cyc=%0d, required mean=%h var=%h fd=%b cyc=%0d",
                     mean_out, variance_out, frame_done, cyc,
                     mon_se.mean, mon_se.vr, mon_se.last, mon_se.cyc);
          end
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_alone: got %b without stats_valid, required 0", frame_done);
      end
      if (data_out_valid) begin
        n_dov++;
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL data_unexpected: got %h at cycle %0d, required none", data_out, cyc);
        end else begin
          mon_de = exp_data_q.pop_front();
          if (data_out !== mon_de.pix || cyc != mon_de.cyc) begin
            errors++;
            $display("FAIL data: got %h cyc=%0d, required %h cyc=%0d",
                     data_out, cyc, mon_de.pix, mon_de.cyc);
          end
        end
      end
    end
  end

  // A write into the bank under readout must only touch indices already emitted.
  always @(posedge clk) begin
    if (rst_n && dut.wr_en && dut.rd_state_q == 1'b1 && dut.wr_bank_q == dut.rd_bank_q &&
        dut.wr_idx > dut.rd_idx_q) begin
      errors++;
      $display("FAIL bank_conflict: write idx %0d into bank %0d, read idx %0d pending",
               dut.wr_idx, dut.wr_bank_q, dut.rd_idx_q);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mean_out !== '0) begin errors++; $display("FAIL reset_mean: got %h required 0", mean_out); end
    checks++; if (variance_out !== '0) begin errors++; $display("FAIL reset_var: got %h required 0", variance_out); end
    checks++; if (stats_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b required 0", stats_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_dout: got %h required 0", data_out); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_dov: got %b required 0", data_out_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b required 0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stats_valid !== 1'b0 || data_out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got sv=%b dov=%b required 0 0", stats_valid, data_out_valid);
    end
  endtask

  task automatic test_ramp();
    logic found;
    logic [15:0] held;
    bpf = 32'd0;
    for (int i = 0; i < N; i++) drive(i == 0, 1'b1, {8'd100, 8'(i)});
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (stats_valid) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL ramp_timeout: got no stats_valid, required one");
    end else begin
      checks++; if (mean_out !== {8'd100, 8'd3}) begin errors++; $display("FAIL ramp_mean: got %h required 6403", mean_out); end
      checks++; if (variance_out !== {16'd0, 16'd8}) begin errors++; $display("FAIL ramp_var: got %h required 00000008", variance_out); end
    end
    held = mean_out;
    repeat (10) @(negedge clk);
    checks++; if (mean_out !== held) begin errors++; $display("FAIL ramp_hold: got %h required %h", mean_out, held); end
    @(posedge clk);
    #1;
    drain(20);
    checks++; if (exp_stats_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++; $display("FAIL ramp_drain: got %0d/%0d pending, required 0/0", exp_stats_q.size(), exp_data_q.size());
    end
  endtask

  task automatic test_alternating();
    logic found;
    for (int i = 0; i < N; i++) drive(i == 0, 1'b1, {8'($urandom), (i % 2 == 1) ? 8'd255 : 8'd0});
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (stats_valid) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL alt_timeout: got no stats_valid, required one");
    end else begin
      checks++; if (mean_out[7:0] !== 8'd127) begin errors++; $display("FAIL alt_mean: got %0d required 127", mean_out[7:0]); end
      checks++; if (variance_out[15:0] !== 16'd16383) begin errors++; $display("FAIL alt_var: got %0d required 16383", variance_out[15:0]); end
    end
    @(posedge clk);
    #1;
    drain(20);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 16'($urandom));
      drive(i == 0, 1'b1, 16'($urandom));
    end
    drain(30);
    checks++; if (exp_stats_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++; $display("FAIL gaps_drain: got %0d/%0d pending, required 0/0", exp_stats_q.size(), exp_data_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int s0, f0;
    bpf = 32'd3;
    s0  = n_stats;
    f0  = n_fd;
    for (int i = 0; i < 3 * N; i++) drive(i == 0, 1'b1, 16'($urandom));
    drive(1'b0, 1'b1, 16'($urandom));
    drain(40);
    repeat (12) drive(1'b0, 1'b0, 16'd0);
    checks++; if (n_stats - s0 != 3) begin errors++; $display("FAIL b2b_stats: got %0d required 3", n_stats - s0); end
    checks++; if (n_fd - f0 != 1) begin errors++; $display("FAIL b2b_frame_done: got %0d required 1", n_fd - f0); end
    checks++; if (exp_stats_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d/%0d pending, required 0/0", exp_stats_q.size(), exp_data_q.size());
    end
    bpf = 32'd0;
  endtask

  task automatic test_restart();
    int s0;
    s0 = n_stats;
    for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, 16'($urandom));
    for (int i = 0; i < N; i++) drive(i == 0, 1'b1, 16'($urandom));
    drain(30);
    repeat (12) drive(1'b0, 1'b0, 16'd0);
    checks++; if (n_stats - s0 != 1) begin errors++; $display("FAIL restart_stats: got %0d required 1", n_stats - s0); end
  endtask

  task automatic test_reset_mid();
    logic found;
    int   s0, d0;
    for (int i = 0; i < N; i++) drive(i == 0, 1'b1, 16'($urandom));
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (data_out_valid) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_timeout: got no data_out_valid, required one"); end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dov: got %b required 0", data_out_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rstmid_dout: got %h required 0", data_out); end
    checks++; if (mean_out !== '0 || variance_out !== '0) begin
      errors++; $display("FAIL rstmid_stats: got mean=%h var=%h required 0 0", mean_out, variance_out);
    end
    checks++; if (stats_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_pulses: got sv=%b fd=%b required 0 0", stats_valid, frame_done);
    end
    exp_stats_q.delete();
    exp_data_q.delete();
    m_active = 1'b0;
    m_idx    = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_stats;
    d0 = n_dov;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (n_stats != s0) begin errors++; $display("FAIL rstmid_stale_stats: got %0d required 0", n_stats - s0); end
    checks++; if (n_dov != d0) begin errors++; $display("FAIL rstmid_stale_data: got %0d required 0", n_dov - d0); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_alternating();
    test_gaps();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
